// File: rtl/counter_chain_sequencer.sv
// -----------------------------------------------------------------------------
// counter_chain_sequencer
//
// Run/stop/clear controller for a 3-stage cascaded 8-bit counter chain
// (e.g. sec/min/hour). A prescaler produces the stage-0 increment tick, and
// carries ripple combinationally from stage 0 to stage 1 to stage 2. All three
// stages update on the same clock edge. Each stage has a wrap limit that can be
// rewritten through a valid/ready config port. Writes are accepted only while
// the chain is not running.
//
// Build option:
//   SEQ_EXT_TICK_EN - when defined, the internal prescaler is removed and the
//                     stage-0 tick comes from tick_in, gated by RUN. PRESCALE
//                     is ignored in that build.
//
// Ports:
//   clk_in         in   1  system clock, posedge
//   rst_in         in   1  synchronous active-high reset
//   start_in       in   1  level: enter/stay RUN
//   stop_in        in   1  level: RUN -> PAUSE
//   clear_in       in   1  level: zero counts and prescaler, go IDLE
//   tick_in        in   1  external stage-0 enable (SEQ_EXT_TICK_EN only)
//   cfg_valid_in   in   1  config write request
//   cfg_ready_out  out  1  config write accepted when valid & ready
//   cfg_sel_in     in   2  stage select 0..2 (3 = handshake only)
//   cfg_limit_in   in   8  new wrap limit for the selected stage
//   stage0_out     out  8  stage-0 count
//   stage1_out     out  8  stage-1 count
//   stage2_out     out  8  stage-2 count
//   tick_out       out  1  1-cycle pulse in the cycle stage 0 shows its new value
//   carry_out      out  1  1-cycle pulse when stage 2 wraps to 0
//   state_out      out  2  00 IDLE, 01 RUN, 10 PAUSE
//
// States:
//   state | meaning
//   IDLE  | counts and prescaler at zero, config writes accepted
//   RUN   | prescaler advancing, chain counting, config writes stalled
//   PAUSE | counts and prescaler held, config writes accepted
// -----------------------------------------------------------------------------
module counter_chain_sequencer #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter logic [7:0]  LIM0_RST = 8'd60,
  parameter logic [7:0]  LIM1_RST = 8'd60,
  parameter logic [7:0]  LIM2_RST = 8'd24
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       clear_in,
`ifdef SEQ_EXT_TICK_EN
  input  logic       tick_in,
`endif
  input  logic       cfg_valid_in,
  output logic       cfg_ready_out,
  input  logic [1:0] cfg_sel_in,
  input  logic [7:0] cfg_limit_in,
  output logic [7:0] stage0_out,
  output logic [7:0] stage1_out,
  output logic [7:0] stage2_out,
  output logic       tick_out,
  output logic       carry_out,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       tick;
  logic       cfg_accept;
  logic [7:0] lim0, lim1, lim2;
  logic [7:0] cnt0, cnt1, cnt2;
  logic       wrap0, wrap1, wrap2;
  logic       en0, en1, en2;
  logic       carry;

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear_in) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_in) state_nxt = ST_RUN;
        ST_RUN:   if (stop_in)  state_nxt = ST_PAUSE;
        ST_PAUSE: begin
          // stop outranks start, so holding stop keeps the chain paused
          if (stop_in)       state_nxt = ST_PAUSE;
          else if (start_in) state_nxt = ST_RUN;
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign state_out     = state;
  assign cfg_ready_out = (state != ST_RUN);
  assign cfg_accept    = cfg_valid_in & cfg_ready_out;

  // ---------------------------------------------------------------------------
  // Stage-0 tick source
  // ---------------------------------------------------------------------------
`ifdef SEQ_EXT_TICK_EN
  assign tick = tick_in & (state == ST_RUN);
`else
  localparam int unsigned        PW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  // Tick fires on the edge the prescaler wraps, so the first tick after
  // leaving IDLE lands PRESCALE cycles later.
  assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in || state == ST_IDLE) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Wrap limits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lim0 <= LIM0_RST;
      lim1 <= LIM1_RST;
      lim2 <= LIM2_RST;
    end else if (cfg_accept) begin
      case (cfg_sel_in)
        2'd0:    lim0 <= cfg_limit_in;
        2'd1:    lim1 <= cfg_limit_in;
        2'd2:    lim2 <= cfg_limit_in;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counter chain
  // ---------------------------------------------------------------------------
  // count + 1 >= limit is count >= limit - 1 without the underflow at limit 0,
  // so limits 0 and 1 both pin the stage at 0 and wrap on every enable. A limit
  // lowered below the current count simply wraps on the next enable.
  assign wrap0 = ({1'b0, cnt0} + 9'd1) >= {1'b0, lim0};
  assign wrap1 = ({1'b0, cnt1} + 9'd1) >= {1'b0, lim1};
  assign wrap2 = ({1'b0, cnt2} + 9'd1) >= {1'b0, lim2};

  assign en0   = tick;
  assign en1   = en0 & wrap0;
  assign en2   = en1 & wrap1;
  assign carry = en2 & wrap2;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      cnt0      <= '0;
      cnt1      <= '0;
      cnt2      <= '0;
      tick_out  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      if (en0) cnt0 <= wrap0 ? 8'd0 : cnt0 + 8'd1;
      if (en1) cnt1 <= wrap1 ? 8'd0 : cnt1 + 8'd1;
      if (en2) cnt2 <= wrap2 ? 8'd0 : cnt2 + 8'd1;
      tick_out  <= tick;
      carry_out <= carry;
    end
  end

  assign stage0_out = cnt0;
  assign stage1_out = cnt1;
  assign stage2_out = cnt2;

endmodule

// File: tb/tb_counter_chain_sequencer.sv
module tb_counter_chain_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start_in = 1'b0;
  logic       stop_in = 1'b0;
  logic       clear_in = 1'b0;
  logic       tick_in = 1'b0;
  logic       cfg_valid_in = 1'b0;
  logic       cfg_ready_out;
  logic [1:0] cfg_sel_in = 2'd0;
  logic [7:0] cfg_limit_in = 8'd0;
  logic [7:0] stage0_out, stage1_out, stage2_out;
  logic       tick_out, carry_out;
  logic [1:0] state_out;

  int n_vec = 0;
  int n_err = 0;
  int carry_cnt = 0;

  counter_chain_sequencer #(
    .PRESCALE(4), .LIM0_RST(8'd60), .LIM1_RST(8'd60), .LIM2_RST(8'd24)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
    .clear_in(clear_in),
`ifdef SEQ_EXT_TICK_EN
    .tick_in(tick_in),
`endif
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
    .cfg_sel_in(cfg_sel_in), .cfg_limit_in(cfg_limit_in),
    .stage0_out(stage0_out), .stage1_out(stage1_out), .stage2_out(stage2_out),
    .tick_out(tick_out), .carry_out(carry_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout, expected summary before 200us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    if (carry_out === 1'b1) carry_cnt++;
  endtask

  // Steps until tick_out rises (bounded) and checks the cycle count.
  task automatic wait_tick(input string tag, input int exp_cycles);
    int n = 0;
    do begin
      step();
      n++;
    end while (tick_out !== 1'b1 && n < exp_cycles + 8);
    chk({tag, " tick latency"}, n, exp_cycles);
  endtask

  task automatic chk_counts(input string tag, input int s0, input int s1, input int s2);
    chk({tag, " stage0"}, {24'd0, stage0_out}, s0);
    chk({tag, " stage1"}, {24'd0, stage1_out}, s1);
    chk({tag, " stage2"}, {24'd0, stage2_out}, s2);
  endtask

  initial begin
    // ---- reset ----
    step();
    step();
    chk_counts("reset", 0, 0, 0);
    chk("reset state", {30'd0, state_out}, 0);
    chk("reset ready", {31'd0, cfg_ready_out}, 1);
    chk("reset tick", {31'd0, tick_out}, 0);
    chk("reset carry", {31'd0, carry_out}, 0);
    rst_in = 1'b0;

    // ---- default limits, 60 ticks ----
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("run state", {30'd0, state_out}, 1);
    chk("run ready", {31'd0, cfg_ready_out}, 0);
    carry_cnt = 0;
    for (int t = 1; t <= 60; t++) begin
      wait_tick("dflt", 4);
      chk("dflt stage0", {24'd0, stage0_out}, t % 60);
    end
    chk_counts("dflt 60 ticks", 0, 1, 0);
    chk("dflt no carry", carry_cnt, 0);

    // ---- stop at stage0=5, prescaler=2 ----
    for (int t = 1; t <= 5; t++) wait_tick("pre-stop", 4);
    step();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    chk("pause state", {30'd0, state_out}, 2);
    chk("pause ready", {31'd0, cfg_ready_out}, 1);
    chk_counts("pause", 5, 1, 0);
    step(); step(); step();
    chk_counts("pause hold", 5, 1, 0);
    chk("pause tick", {31'd0, tick_out}, 0);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("resume state", {30'd0, state_out}, 1);
    wait_tick("resume", 2);
    chk_counts("resume", 6, 1, 0);

    // ---- clear+stop+start same cycle in RUN with a config write held ----
    clear_in = 1'b1; stop_in = 1'b1; start_in = 1'b1;
    cfg_valid_in = 1'b1; cfg_sel_in = 2'd0; cfg_limit_in = 8'd3;
    chk("clr pre ready", {31'd0, cfg_ready_out}, 0);
    step();
    clear_in = 1'b0; stop_in = 1'b0; start_in = 1'b0;
    chk("clr state", {30'd0, state_out}, 0);
    chk_counts("clr", 0, 0, 0);
    chk("clr ready", {31'd0, cfg_ready_out}, 1);
    step();
    cfg_sel_in = 2'd1; cfg_limit_in = 8'd2;
    step();
    cfg_sel_in = 2'd2; cfg_limit_in = 8'd2;
    step();
    cfg_sel_in = 2'd3; cfg_limit_in = 8'd0;
    step();
    cfg_valid_in = 1'b0;
    chk("cfg idle state", {30'd0, state_out}, 0);

    // ---- limits 3,2,2: carry on ticks 12 and 24 ----
    carry_cnt = 0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      wait_tick("lim322", 4);
      chk_counts("lim322", t % 3, (t / 3) % 2, (t / 6) % 2);
      chk("lim322 carry", {31'd0, carry_out}, (t % 12 == 0) ? 1 : 0);
    end
    chk("lim322 carry count", carry_cnt, 2);

    // ---- config write during RUN stalls ----
    cfg_valid_in = 1'b1; cfg_sel_in = 2'd0; cfg_limit_in = 8'd1;
    chk("stall ready", {31'd0, cfg_ready_out}, 0);
    wait_tick("stall", 4);
    chk("stall ready held", {31'd0, cfg_ready_out}, 0);
    chk("stall old limit", {24'd0, stage0_out}, 1);
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    chk("stall paused ready", {31'd0, cfg_ready_out}, 1);
    step();
    cfg_valid_in = 1'b0;
    carry_cnt = 0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    wait_tick("lim1 first", 3);
    chk_counts("lim1 k1", 0, 1, 0);
    for (int k = 2; k <= 4; k++) begin
      wait_tick("lim1", 4);
      chk_counts("lim1", 0, k % 2, (k / 2) % 2);
      chk("lim1 carry", {31'd0, carry_out}, (k % 4 == 0) ? 1 : 0);
    end
    chk("lim1 carry count", carry_cnt, 1);

    // ---- reset mid-RUN reverts limits ----
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk_counts("midrst", 0, 0, 0);
    chk("midrst state", {30'd0, state_out}, 0);
    chk("midrst ready", {31'd0, cfg_ready_out}, 1);
    chk("midrst tick", {31'd0, tick_out}, 0);
    chk("midrst carry", {31'd0, carry_out}, 0);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int t = 1; t <= 3; t++) wait_tick("midrst run", 4);
    chk_counts("midrst run", 3, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
